aes_inv_cipher_seq: RTL
=======================

# aes_inv_cipher_seq

Iterative AES-128 decryption sequencer: accepts one 128-bit ciphertext block, runs the ten inverse rounds over a single shared combinational round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns), and returns the plaintext block. It sits between the block-level valid/ready stream and the expanded-key store. It reads one round key per cycle by index and performs no key expansion itself.

## Interface

- `NR`, default 10: number of AES rounds. Only 10 (AES-128) is supported.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: ciphertext offered.
- `in_ready` output 1: block can be accepted. High only in IDLE.
- `ciphertext` input [0:127]: byte 0 in bits [0:7], column-major state order.
- `key_idx` output 4: index of the round key required this cycle, range 0..10.
- `round_key` input [0:127]: key for `key_idx`. Valid combinationally in the same cycle.
- `out_valid` output 1: plaintext available.
- `out_ready` input 1: consumer accepts plaintext.
- `plaintext` output [0:127]: result. Driven from the state register.
- `busy` output 1: high in ROUND, FINAL and DONE.

## Operation

- FSM states: IDLE, ROUND, FINAL, DONE.
- Registers: `state` [0:127], `round` (4 bits).
- IDLE:
  - `key_idx`=10 and `in_ready`=1.
  - On `in_valid`: `state` ← `ciphertext` ^ `round_key`, `round` ← 9, go to ROUND.
- ROUND:
  - `key_idx`=`round`.
  - `state` ← InvMixColumns(InvSubBytes(InvShiftRows(`state`)) ^ `round_key`).
  - If `round`==1, set `round` ← 0 and go to FINAL. Otherwise decrement `round`.
- FINAL:
  - `key_idx`=0.
  - `state` ← InvSubBytes(InvShiftRows(`state`)) ^ `round_key`.
  - Go to DONE.
- DONE:
  - `out_valid`=1 and `plaintext`=`state`. Both are held stable until `out_ready`.
  - On `out_ready`, go to IDLE.
- `key_idx` in DONE is 0 (don't-care for the key store). It must never be outside 0..10.
- `in_valid` outside IDLE is ignored. No block is queued, and `ciphertext` is sampled only on the accept edge.
- `out_ready` outside DONE is ignored.
- `ciphertext` and `round_key` values outside their sampling cycle have no effect.
- Reset (asynchronous, at any point, including mid-round):
  - FSM → IDLE, `state` → 0, `round` → 0.
  - Outputs: `in_ready`=1, `out_valid`=0, `busy`=0, `plaintext`=0, `key_idx`=10.
  - The in-flight block is discarded and no `out_valid` is produced for it.

## Timing

- Accept edge A: `in_valid` & `in_ready`.
- ROUND occupies 9 cycles (rounds 9..1). FINAL occupies 1 cycle.
- `out_valid` rises exactly 10 cycles after A (first cycle after the FINAL edge).
- If `out_ready` is already high, DONE lasts 1 cycle and `in_ready` is high again 11 cycles after A.
- Minimum initiation interval is 12 cycles: one IDLE accept cycle plus 11.
- Backpressure: each cycle of `out_ready` low extends DONE by one cycle. `plaintext` is unchanged during the stall.
- Round datapath is single-cycle combinational from `state`/`round_key` to `state`. `round_key` path: `key_idx` → external store → datapath in one cycle.

## Structure

- Shared package `aes_pkg`:
  - `NR`=10.
  - `NK_IDX_W`=4.
  - FSM state encoding (2-bit localparams).
- Sub-module `aes_inv_round`: combinational round datapath.
  - Instantiates the existing InvShiftRows, InvSubBytes and InvMixColumns blocks plus the XOR.
  - Select input `last` bypasses InvMixColumns for FINAL.
- The sequencer holds only the FSM, counter, state register and muxes.

## Test plan

- FIPS-197 C.1 vector:
  - Key schedule model for key 000102030405060708090a0b0c0d0e0f.
  - `ciphertext`=69c4e0d86a7b0430d8cdb78070b4c55a → `plaintext`=00112233445566778899aabbccddeeff.
  - `out_valid` exactly 10 cycles after accept.
  - `key_idx` sequence 10,9,…,1,0.
- Backpressure:
  - Same vector, `out_ready` held low 5 cycles after `out_valid`.
  - `plaintext` stable throughout, `in_ready`=0, single handshake on release.
- Back-to-back:
  - Two blocks with `in_valid` held high: C.1 vector, then ciphertext 3ad77bb40d7a3660a89ecaf32466ef97 with key 2b7e151628aed2a6abf7158809cf4f3c.
  - Second result 6bc1bee22e409f96e93d7e117393172a.
  - Second accept occurs 12 cycles after the first.
- Ignored inputs:
  - Toggle `in_valid` and change `ciphertext` while in ROUND.
  - Result is unchanged; no extra accept occurs.
- Reset mid-operation:
  - Assert `rst` during ROUND with `round`=5.
  - Immediately: `out_valid`=0, `in_ready`=1, `key_idx`=10, `plaintext`=0.
  - A subsequent C.1 run is still correct.
- Reset values:
  - Assert `rst` with no clock edges.
  - All outputs at reset values, checked asynchronously.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and the byte/column transforms used by
// the inverse round datapath. State vectors are [0:127], byte b at [8b +: 8].
package aes_pkg;

    localparam int NR       = 10;
    localparam int NK_IDX_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and conveniently maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(r+4*c) +: 8] = s[8*(r+4*((c+4-r)%4)) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int b = 0; b < 16; b++) begin
            o[8*b +: 8] = inv_sbox(s[8*b +: 8]);
        end
        return o;
    endfunction

    function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            o[32*c +: 8]    = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[32*c+8 +: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[32*c+16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[32*c+24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [0:127] state_i,
    input  logic [0:127] round_key_i,
    input  logic         last_i,
    output logic [0:127] state_o
);

    logic [0:127] keyed;

    assign keyed   = inv_sub_bytes(inv_shift_rows(state_i)) ^ round_key_i;
    assign state_o = last_i ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_inv_cipher_seq.sv
// Iterative AES-128 decryption sequencer: one shared inverse round per cycle,
// round keys fetched by index from an external expanded-key store.
module aes_inv_cipher_seq
    import aes_pkg::*;
#(
    parameter int NR = aes_pkg::NR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [0:127]        ciphertext,
    output logic [NK_IDX_W-1:0] key_idx,
    input  logic [0:127]        round_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [0:127]        plaintext,
    output logic                busy
);

    logic [1:0]   fsm_q, fsm_d;
    logic [0:127] state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [0:127] round_out;

    aes_inv_round u_round (
        .state_i     (state_q),
        .round_key_i (round_key),
        .last_i      (fsm_q == ST_FINAL),
        .state_o     (round_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        case (fsm_q)
            ST_IDLE: begin
                // Initial AddRoundKey uses the last schedule key
                if (in_valid) begin
                    state_d = ciphertext ^ round_key;
                    round_d = 4'(NR - 1);
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_d = round_out;
                if (round_q == 4'd1) begin
                    round_d = 4'd0;
                    fsm_d   = ST_FINAL;
                end else begin
                    round_d = round_q - 4'd1;
                end
            end
            ST_FINAL: begin
                state_d = round_out;
                fsm_d   = ST_DONE;
            end
            default: begin
                if (out_ready) fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            round_q <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        case (fsm_q)
            ST_IDLE:  key_idx = NK_IDX_W'(NR);
            ST_ROUND: key_idx = round_q;
            default:  key_idx = '0;
        endcase
    end

    assign in_ready  = (fsm_q == ST_IDLE);
    assign out_valid = (fsm_q == ST_DONE);
    assign busy      = (fsm_q != ST_IDLE);
    assign plaintext = state_q;

endmodule
